t05_sram_arbiter: RTL and testbench

Round-robin arbiter that shares the single SRAM word port among the Huffman-stage requesters: histogram, find-least, tree builder and codebook generator. Each requester issues one read or write at a time. The arbiter serialises the requests onto the SRAM port, holds address and data stable until the memory acknowledges, then returns a one-cycle done pulse and the read data to the winning requester.

---
 rtl/t05_sram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_t05_sram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto a single SRAM word port.
// Optional: define T05_ARB_TIMEOUT_EN to abort transactions whose mem_ack never arrives.
module t05_sram_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("t05_sram_arbiter: NREQ must be >= 2 and TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  last, last_nxt;
    logic [IDX_W-1:0]  cur, cur_nxt;
    logic [IDX_W-1:0]  sel, cand;
    logic              found;
    logic              finish;
    logic              tmo;
    logic [NREQ-1:0]   gnt_nxt, done_nxt;
    logic [DATA_W-1:0] rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_req_nxt, mem_we_nxt;

`ifdef T05_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt, tmo_cnt_nxt;
    logic       err_q, err_nxt;

    // Fires on the cycle the count would reach TIMEOUT, so done lands TIMEOUT cycles after mem_req rose.
    assign tmo = (state == ISSUE) && !mem_ack && (tmo_cnt == 8'(TIMEOUT - 1));
    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    assign finish = (state == ISSUE) && (mem_ack || tmo);
    assign busy   = (state != IDLE);

    // Rotating priority search: starts just after the last served index and wraps.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(last) + 1 + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)  state_nxt = ISSUE;
            ISSUE:   if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output; the SRAM side only changes on entry to ISSUE or DONE.
    always_comb begin
        gnt_nxt       = gnt;
        done_nxt      = '0;
        rdata_nxt     = rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        last_nxt      = last;
        cur_nxt       = cur;
`ifdef T05_ARB_TIMEOUT_EN
        tmo_cnt_nxt   = tmo_cnt;
        err_nxt       = err_q;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt       = '0;
                    gnt_nxt[sel]  = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = we[sel];
                    mem_addr_nxt  = addr[int'(sel)*ADDR_W +: ADDR_W];
                    mem_wdata_nxt = wdata[int'(sel)*DATA_W +: DATA_W];
                    cur_nxt       = sel;
`ifdef T05_ARB_TIMEOUT_EN
                    tmo_cnt_nxt   = '0;
`endif
                end
            end
            ISSUE: begin
                if (finish) begin
                    gnt_nxt       = '0;
                    mem_req_nxt   = 1'b0;
                    done_nxt[cur] = 1'b1;
                    last_nxt      = cur;
                    if (mem_ack) begin
                        if (!mem_we) rdata_nxt = mem_rdata;
                    end
`ifdef T05_ARB_TIMEOUT_EN
                    else begin
                        rdata_nxt = '0;
                        err_nxt   = 1'b1;
                    end
`endif
                end
`ifdef T05_ARB_TIMEOUT_EN
                else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last      <= IDX_W'(NREQ - 1);
            cur       <= '0;
`ifdef T05_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            rdata     <= rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            last      <= last_nxt;
            cur       <= cur_nxt;
`ifdef T05_ARB_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed testbench for t05_sram_arbiter: reset, reads, writes, rotation, async reset and timeout.
// Covers the T05_ARB_TIMEOUT_EN build when that macro is defined.
module tb_t05_sram_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [31:0]  rdata;
    logic         busy;
    logic         err;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;

    logic         zero_wait;
    logic         ack_drv;
    logic [31:0]  rdata_drv;

    int checks   = 0;
    int failures = 0;

    // Zero-wait memory acknowledges in the same cycle mem_req rises and echoes a scrambled address.
    assign mem_ack   = zero_wait ? mem_req : ack_drv;
    assign mem_rdata = zero_wait ? (mem_addr ^ 32'hA5A5_0000) : rdata_drv;

    t05_sram_arbiter #(
        .NREQ    (4),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req       = '0;
        we        = '0;
        zero_wait = 1'b0;
        ack_drv   = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        zero_wait = 1'b0;
        ack_drv   = 1'b0;
        rdata_drv = '0;
        #3;
        checks++; if (gnt !== 4'b0) begin failures++; $display("[TB] FAIL rst_gnt: got %b want 0000", gnt); end
        checks++; if (done !== 4'b0) begin failures++; $display("[TB] FAIL rst_done: got %b want 0000", done); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata: got %h want 0", rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b want 0", err); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_read;
        ack_drv   = 1'b1;
        rdata_drv = 32'h5555;
        tick;
        ack_drv = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 4'b0) begin failures++; $display("[TB] FAIL idle_ack_ignored: got busy=%b done=%b want 0/0000", busy, done); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL idle_ack_rdata: got %h want 0", rdata); end

        we         = 4'b0000;
        addr[31:0] = 32'h10;
        req        = 4'b0001;
        tick;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL rd_gnt: got %b want 0001", gnt); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rd_mem_req: got req=%b we=%b want 1/0", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h10) begin failures++; $display("[TB] FAIL rd_mem_addr: got %h want 10", mem_addr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rd_busy: got %b want 1", busy); end
        tick;
        checks++; if (done !== 4'b0 || mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rd_wait: got done=%b mem_req=%b want 0000/1", done, mem_req); end
        ack_drv   = 1'b1;
        rdata_drv = 32'hCAFE;
        tick;
        ack_drv   = 1'b0;
        rdata_drv = 32'hDEAD;
        req       = 4'b0000;
        checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL rd_done: got %b want 0001", done); end
        checks++; if (rdata !== 32'hCAFE) begin failures++; $display("[TB] FAIL rd_rdata: got %h want cafe", rdata); end
        checks++; if (mem_req !== 1'b0 || gnt !== 4'b0) begin failures++; $display("[TB] FAIL rd_release: got mem_req=%b gnt=%b want 0/0000", mem_req, gnt); end
        tick;
        checks++; if (done !== 4'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rd_done_pulse: got done=%b busy=%b want 0000/0", done, busy); end
        repeat (3) tick;
        checks++; if (rdata !== 32'hCAFE) begin failures++; $display("[TB] FAIL rd_rdata_hold: got %h want cafe", rdata); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        logic [3:0] exp_done;
        int         k;
        do_reset;
        for (int i = 0; i < 4; i++) addr[i*32 +: 32] = 32'h100 + 32'(i);
        we        = 4'b0000;
        zero_wait = 1'b1;
        req       = 4'b1111;
        for (int t = 1; t <= 24; t++) begin
            tick;
            k        = ((t - 1) / 3) % 4;
            exp_gnt  = (t % 3 == 1) ? (4'b0001 << k) : 4'b0000;
            exp_done = (t % 3 == 2) ? (4'b0001 << k) : 4'b0000;
            checks++; if (gnt !== exp_gnt) begin failures++; $display("[TB] FAIL rr_gnt t=%0d: got %b want %b", t, gnt, exp_gnt); end
            checks++; if (done !== exp_done) begin failures++; $display("[TB] FAIL rr_done t=%0d: got %b want %b", t, done, exp_done); end
            if (t % 3 == 2) begin
                checks++; if (rdata !== (32'hA5A5_0100 + 32'(k))) begin failures++; $display("[TB] FAIL rr_rdata t=%0d: got %h want %h", t, rdata, 32'hA5A5_0100 + 32'(k)); end
            end
        end
        req = 4'b0000;
        tick;
        zero_wait = 1'b0;
    endtask

    task automatic test_write_dropped_req;
        req            = 4'b0100;
        we             = 4'b0100;
        addr[64 +: 32]  = 32'h44;
        wdata[64 +: 32] = 32'hAB;
        tick;
        checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL wr_gnt: got %b want 0100", gnt); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'hAB) begin failures++; $display("[TB] FAIL wr_issue: got we=%b addr=%h data=%h want 1/44/ab", mem_we, mem_addr, mem_wdata); end
        req             = 4'b0000;
        we              = 4'b0000;
        addr[64 +: 32]  = 32'h999;
        wdata[64 +: 32] = 32'h777;
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'hAB || mem_we !== 1'b1) begin failures++; $display("[TB] FAIL wr_frozen: got req=%b we=%b addr=%h data=%h want 1/1/44/ab", mem_req, mem_we, mem_addr, mem_wdata); end
        ack_drv   = 1'b1;
        rdata_drv = 32'h1234;
        tick;
        ack_drv = 1'b0;
        checks++; if (done !== 4'b0100) begin failures++; $display("[TB] FAIL wr_done: got %b want 0100", done); end
        checks++; if (rdata !== 32'hA5A5_0103) begin failures++; $display("[TB] FAIL wr_rdata_kept: got %h want a5a50103", rdata); end
        tick;
        checks++; if (done !== 4'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL wr_end: got done=%b busy=%b want 0000/0", done, busy); end
    endtask

    task automatic test_wrap;
        zero_wait = 1'b1;
        we        = 4'b0000;
        req       = 4'b1000;
        tick;
        checks++; if (gnt !== 4'b1000) begin failures++; $display("[TB] FAIL wrap_first: got %b want 1000", gnt); end
        tick;
        req = 4'b1001;
        repeat (2) tick;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL wrap_gnt0: got %b want 0001", gnt); end
        tick;
        checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL wrap_done0: got %b want 0001", done); end
        req = 4'b1000;
        repeat (2) tick;
        checks++; if (gnt !== 4'b1000) begin failures++; $display("[TB] FAIL wrap_gnt3: got %b want 1000", gnt); end
        tick;
        req = 4'b0000;
        tick;
        zero_wait = 1'b0;
    endtask

    task automatic test_reset_mid_issue;
        zero_wait = 1'b1;
        req       = 4'b0010;
        repeat (2) tick;
        req = 4'b0000;
        tick;
        zero_wait = 1'b0;
        req       = 4'b0100;
        tick;
        checks++; if (mem_req !== 1'b1 || gnt !== 4'b0100) begin failures++; $display("[TB] FAIL mid_pre: got mem_req=%b gnt=%b want 1/0100", mem_req, gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_mem_req: got %b want 0", mem_req); end
        checks++; if (gnt !== 4'b0) begin failures++; $display("[TB] FAIL mid_gnt: got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
        req = 4'b0000;
        repeat (2) tick;
        #3;
        rst_n     = 1'b1;
        zero_wait = 1'b1;
        req       = 4'b0111;
        tick;
        checks++; if (gnt !== 4'b0001 || done !== 4'b0) begin failures++; $display("[TB] FAIL mid_after_gnt: got gnt=%b done=%b want 0001/0000", gnt, done); end
        tick;
        checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL mid_after_done: got %b want 0001", done); end
        req = 4'b0000;
        tick;
        zero_wait = 1'b0;
    endtask

`ifdef T05_ARB_TIMEOUT_EN
    task automatic test_timeout;
        we  = 4'b0000;
        req = 4'b0001;
        tick;
        checks++; if (mem_req !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_start: got mem_req=%b err=%b want 1/0", mem_req, err); end
        for (int i = 2; i <= 8; i++) begin
            tick;
            checks++; if (done !== 4'b0 || mem_req !== 1'b1) begin failures++; $display("[TB] FAIL tmo_wait c=%0d: got done=%b mem_req=%b want 0000/1", i, done, mem_req); end
        end
        tick;
        checks++; if (done !== 4'b0001) begin failures++; $display("[TB] FAIL tmo_done: got %b want 0001", done); end
        checks++; if (err !== 1'b1 || rdata !== 32'h0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL tmo_flags: got err=%b rdata=%h mem_req=%b want 1/0/0", err, rdata, mem_req); end
        req = 4'b0000;
        tick;
        checks++; if (done !== 4'b0 || err !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL tmo_after: got done=%b err=%b busy=%b want 0000/1/0", done, err, busy); end
        addr[32 +: 32] = 32'h20;
        req            = 4'b0010;
        tick;
        checks++; if (gnt !== 4'b0010 || mem_addr !== 32'h20) begin failures++; $display("[TB] FAIL tmo_next_gnt: got gnt=%b addr=%h want 0010/20", gnt, mem_addr); end
        ack_drv   = 1'b1;
        rdata_drv = 32'hBEEF;
        tick;
        ack_drv = 1'b0;
        req     = 4'b0000;
        checks++; if (done !== 4'b0010 || rdata !== 32'hBEEF || err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_next_done: got done=%b rdata=%h err=%b want 0010/beef/1", done, rdata, err); end
        tick;
    endtask
`else
    task automatic test_no_timeout;
        we  = 4'b0000;
        req = 4'b0001;
        repeat (20) tick;
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1 || done !== 4'b0) begin failures++; $display("[TB] FAIL notmo_wait: got mem_req=%b busy=%b done=%b want 1/1/0000", mem_req, busy, done); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL notmo_err: got %b want 0", err); end
        ack_drv   = 1'b1;
        rdata_drv = 32'h0BAD_F00D;
        tick;
        ack_drv = 1'b0;
        req     = 4'b0000;
        checks++; if (done !== 4'b0001 || rdata !== 32'h0BAD_F00D) begin failures++; $display("[TB] FAIL notmo_done: got done=%b rdata=%h want 0001/0badf00d", done, rdata); end
        tick;
    endtask
`endif

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_single_read;
        test_round_robin;
        test_write_dropped_req;
        test_wrap;
        test_reset_mid_issue;
`ifdef T05_ARB_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
